crc_code_read_checker: RTL and testbench

//  Read-side counterpart of the CRC write path: accepts a read request, fetches the 12-bit codeword
//  {data[7:0], crc[3:0]} from the CRC memory and checks it bit-serially with an LFSR divider.
//  It returns the data byte with an error flag and a data_valid pulse.

---
 rtl/crc_code_pkg.sv | 53 +++++
 rtl/crc_code_syndrome_lfsr.sv | 40 ++++
 rtl/crc_code_read_checker.sv | 139 +++++++++++++
 tb/tb_crc_code_read_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/crc_code_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : crc_code_pkg                                               |
// | Description : Shared constants for the CRC codeword path: field widths,  |
// |               generator polynomial, read-checker state encoding and the  |
// |               syndrome -> bit-position table (syn_to_pos).               |
// |               Codeword layout: cw[11:4] = data, cw[3:0] = crc.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package crc_code_pkg;

   localparam int DATA_W = 8;
   localparam int CRC_W  = 4;
   localparam int CW_W   = DATA_W + CRC_W;
   localparam int ADDR_W = 4;

   // x^4 + x + 1 with the implicit x^4 term dropped
   localparam logic [CRC_W-1:0] POLY = 4'b0011;

   // Read-checker states
   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_fetch = 2'd1;
   localparam logic [1:0] c_shift = 2'd2;
   localparam logic [1:0] c_done  = 2'd3;

   // Returned by syn_to_pos when the syndrome is zero or matches no single bit
   localparam logic [3:0] c_pos_invalid = 4'hF;

   // Syndrome of a single-bit error at codeword bit i is x^i mod G.
   // The three nonzero syndromes not in this table (1001/1101/1111) can
   // only come from multi-bit errors.
   function automatic logic [3:0] syn_to_pos(input logic [CRC_W-1:0] syn);
      logic [3:0] pos;
      case (syn)
         4'b0001: pos = 4'd0;
         4'b0010: pos = 4'd1;
         4'b0100: pos = 4'd2;
         4'b1000: pos = 4'd3;
         4'b0011: pos = 4'd4;
         4'b0110: pos = 4'd5;
         4'b1100: pos = 4'd6;
         4'b1011: pos = 4'd7;
         4'b0101: pos = 4'd8;
         4'b1010: pos = 4'd9;
         4'b0111: pos = 4'd10;
         4'b1110: pos = 4'd11;
         default: pos = c_pos_invalid;
      endcase
      return pos;
   endfunction

endpackage
`default_nettype wire

// File: rtl/crc_code_syndrome_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : crc_code_syndrome_lfsr                                     |
// | Description : Bit-serial polynomial divider. Feeding a codeword MSB      |
// |               first leaves cw(x) mod G(x) in syn.                        |
// | Ports       : clk, rst (async, active-high)                              |
// |               clear    - synchronous clear of the remainder              |
// |               shift_en - advance one bit                                 |
// |               bit_in   - next codeword bit (MSB first)                   |
// |               syn      - current remainder                               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module crc_code_syndrome_lfsr
   import crc_code_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] syn
);

   logic [CRC_W-1:0] r_syn;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_syn <= '0;
      end else if (clear) begin
         r_syn <= '0;
      end else if (shift_en) begin
         // Reduce by G whenever the x^4 term would overflow
         r_syn <= {r_syn[CRC_W-2:0], bit_in} ^ (r_syn[CRC_W-1] ? POLY : '0);
      end
   end

   assign syn = r_syn;

endmodule
`default_nettype wire

// File: rtl/crc_code_read_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : crc_code_read_checker                                      |
// | Description : Fetches a 12-bit codeword {data, crc} from the CRC memory  |
// |               and checks it serially, returning the data byte with an    |
// |               error flag and a one-cycle data_valid pulse.               |
// | Ports       : clk, rst (async, active-high)                              |
// |               read, addr_in             - user read request              |
// |               mem_read_addr, mem_read_data - memory side                 |
// |               read_busy                 - high outside IDLE              |
// |               data_valid, data_out, error_detected, error_corrected      |
// | Config      : `define CRC_CORRECT_EN enables single-bit correction.      |
// |               Without it error_corrected is tied low.                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module crc_code_read_checker
   import crc_code_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              read,
   input  logic [ADDR_W-1:0] addr_in,
   output logic [ADDR_W-1:0] mem_read_addr,
   input  logic [CW_W-1:0]   mem_read_data,
   output logic              read_busy,
   output logic              data_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              error_detected,
   output logic              error_corrected
);

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic [CW_W-1:0]   r_cw;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data_out;
   logic              r_err_det;

   logic [CRC_W-1:0]  w_syn;
   logic [CW_W-1:0]   w_cw_fix;
   logic              w_det;
   logic              w_done;

   assign w_done = (r_state == c_done);

   crc_code_syndrome_lfsr u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .clear    (r_state == c_fetch),
      .shift_en (r_state == c_shift),
      .bit_in   (r_cw[CW_W-1]),
      .syn      (w_syn)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_idle;
         r_cnt      <= '0;
         r_cw       <= '0;
         r_addr     <= '0;
         r_data_out <= '0;
         r_err_det  <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (read) begin
                  r_addr  <= addr_in;
                  r_state <= c_fetch;
               end
            end
            c_fetch: begin
               r_cw    <= mem_read_data;
               r_cnt   <= '0;
               r_state <= c_shift;
            end
            c_shift: begin
               // Rotate rather than shift so the full codeword is intact
               // again after the 12th step and can be corrected in DONE.
               r_cw  <= {r_cw[CW_W-2:0], r_cw[CW_W-1]};
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'(CW_W - 1)) begin
                  r_state <= c_done;
               end
            end
            default: begin
               r_data_out <= w_cw_fix[CW_W-1:CRC_W];
               r_err_det  <= w_det;
               r_state    <= c_idle;
            end
         endcase
      end
   end

`ifdef CRC_CORRECT_EN
   logic [3:0] w_pos;
   logic       w_cor;
   logic       r_err_cor;

   assign w_pos = syn_to_pos(w_syn);

   always_comb begin
      w_cw_fix = r_cw;
      w_det    = 1'b0;
      w_cor    = 1'b0;
      if (w_syn != '0) begin
         if (w_pos != c_pos_invalid) begin
            w_cw_fix = r_cw ^ ({{(CW_W-1){1'b0}}, 1'b1} << w_pos);
            w_cor    = 1'b1;
         end else begin
            w_det    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cor <= 1'b0;
      end else if (w_done) begin
         r_err_cor <= w_cor;
      end
   end

   assign error_corrected = w_done ? w_cor : r_err_cor;
`else
   assign w_cw_fix        = r_cw;
   assign w_det           = |w_syn;
   assign error_corrected = 1'b0;
`endif

   // The final syndrome only exists during DONE, so the result is shown
   // combinationally in that cycle and held in registers afterwards.
   assign data_out       = w_done ? w_cw_fix[CW_W-1:CRC_W] : r_data_out;
   assign error_detected = w_done ? w_det : r_err_det;
   assign data_valid     = w_done;
   assign read_busy      = (r_state != c_idle);
   assign mem_read_addr  = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_crc_code_read_checker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_crc_code_read_checker                                   |
// | Description : Self-checking bench for crc_code_read_checker. Memory is a |
// |               combinational array; expected results come from            |
// |               polynomial long division done in plain arithmetic.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_crc_code_read_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read = 1'b0;
   logic [3:0]  addr_in = '0;
   logic [3:0]  mem_read_addr;
   logic [11:0] mem_read_data;
   logic        read_busy;
   logic        data_valid;
   logic [7:0]  data_out;
   logic        error_detected;
   logic        error_corrected;

   logic [11:0] mem [16];

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign mem_read_data = mem[mem_read_addr];

   crc_code_read_checker dut (
      .clk             (clk),
      .rst             (rst),
      .read            (read),
      .addr_in         (addr_in),
      .mem_read_addr   (mem_read_addr),
      .mem_read_data   (mem_read_data),
      .read_busy       (read_busy),
      .data_valid      (data_valid),
      .data_out        (data_out),
      .error_detected  (error_detected),
      .error_corrected (error_corrected)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Remainder of v(x) divided by x^4+x+1
   function automatic logic [3:0] mod_g(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      for (int i = 11; i >= 4; i--) begin
         if (r[i]) r = r ^ (12'h013 << (i - 4));
      end
      return r[3:0];
   endfunction

   function automatic logic [11:0] encode(input logic [7:0] d);
      return {d, mod_g({d, 4'h0})};
   endfunction

   task automatic model(input logic [11:0] cw, output logic [7:0] d,
                        output logic det, output logic cor);
      logic [3:0]  rem;
      logic [11:0] fixed;
      rem   = mod_g(cw);
      fixed = cw;
      det   = 1'b0;
      cor   = 1'b0;
      if (rem != 4'h0) begin
`ifdef CRC_CORRECT_EN
         det = 1'b1;
         for (int i = 0; i < 12; i++) begin
            if (mod_g(12'h001 << i) == rem) begin
               fixed = cw ^ (12'h001 << i);
               cor   = 1'b1;
               det   = 1'b0;
            end
         end
`else
         det = 1'b1;
`endif
      end
      d = fixed[11:4];
   endtask

   // One read at address a. dup (1..14) re-asserts read before that edge
   // while the checker is busy; it must be ignored.
   task automatic do_read(input logic [3:0] a, input logic [11:0] cw, input int dup);
      logic [7:0] ed;
      logic       edet, ecor;
      model(cw, ed, edet, ecor);
      mem[a] = cw;
      @(negedge clk);
      read    = 1'b1;
      addr_in = a;
      @(negedge clk);                       // request edge E0 has passed
      read    = 1'b0;
      addr_in = 4'($urandom);
      check("mem_read_addr", mem_read_addr, a);
      check("busy_e0", read_busy, 1'b1);
      check("valid_e0", data_valid, 1'b0);
      for (int k = 1; k <= 14; k++) begin
         read = (k == dup);
         @(negedge clk);
         if (k == 2) mem[a] = 12'($urandom);   // codeword already captured
         check("valid", data_valid, (k == 13));
         check("busy", read_busy, (k <= 13));
         if (k == 13 || k == 14) begin
            check("data_out", data_out, ed);
            check("err_det", error_detected, edet);
            check("err_cor", error_corrected, ecor);
         end
      end
      read = 1'b0;
   endtask

   initial begin
      logic [7:0]  d;
      logic [11:0] cw;
      int          nvalid;
      int          next_free;
      logic        exp_v  [64];
      logic [11:0] exp_cw [64];
      logic [7:0]  ed;
      logic        edet, ecor;

      for (int i = 0; i < 16; i++) mem[i] = '0;

      // Reset state
      #1;
      check("rst_data", data_out, 8'h00);
      check("rst_valid", data_valid, 1'b0);
      check("rst_busy", read_busy, 1'b0);
      check("rst_det", error_detected, 1'b0);
      check("rst_cor", error_corrected, 1'b0);
      check("rst_addr", mem_read_addr, 4'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Clean word, single-bit error, double error with unmapped syndrome
      do_read(4'd3, 12'hA5B, 0);
      do_read(4'd3, 12'hA4B, 0);
      do_read(4'd3, 12'hA52, 0);

      // Second request during SHIFT is dropped
      do_read(4'd5, 12'h3C0 ^ 12'h001, 6);
      do_read(4'd6, encode(8'h5A), 14);

      // Randomized words: clean, 1-bit, 2-bit and arbitrary corruption
      for (int n = 0; n < 24; n++) begin
         d  = 8'($urandom);
         cw = encode(d);
         case ($urandom_range(0, 3))
            1: cw = cw ^ (12'h001 << $urandom_range(0, 11));
            2: cw = cw ^ (12'h001 << $urandom_range(0, 5)) ^ (12'h040 << $urandom_range(0, 5));
            3: cw = 12'($urandom);
            default: ;
         endcase
         do_read(4'($urandom), cw, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 14) : 0);
      end

      // Reset in the middle of SHIFT: aborts with outputs cleared
      do_read(4'd3, 12'hA5B, 0);
      @(negedge clk);
      read    = 1'b1;
      addr_in = 4'd3;
      @(negedge clk);
      read    = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_data", data_out, 8'h00);
      check("abort_busy", read_busy, 1'b0);
      check("abort_valid", data_valid, 1'b0);
      check("abort_det", error_detected, 1'b0);
      @(negedge clk);
      rst    = 1'b0;
      nvalid = 0;
      repeat (16) begin
         @(negedge clk);
         if (data_valid) nvalid++;
      end
      check("abort_no_valid", nvalid, 0);
      do_read(4'd3, 12'hA5B, 0);

      // read held high for 30 edges alternating addresses 0/1. A request is
      // taken only when the checker is idle; a read taken at edge e keeps it
      // busy through edge e+14, so the next one can start at edge e+15.
      mem[0] = encode(8'($urandom));
      mem[1] = encode(8'($urandom)) ^ 12'h010;
      for (int e = 0; e < 64; e++) exp_v[e] = 1'b0;
      next_free = 0;
      for (int e = 0; e < 30; e++) begin
         if (e >= next_free) begin
            exp_v[e + 13]  = 1'b1;
            exp_cw[e + 13] = mem[e % 2];
            next_free      = e + 15;
         end
      end
      @(negedge clk);
      for (int e = 0; e < 50; e++) begin
         read    = (e < 30);
         addr_in = 4'(e % 2);
         @(negedge clk);
         check("held_valid", data_valid, exp_v[e]);
         if (exp_v[e]) begin
            model(exp_cw[e], ed, edet, ecor);
            check("held_data", data_out, ed);
            check("held_det", error_detected, edet);
            check("held_cor", error_corrected, ecor);
         end
      end
      read = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
